// File: rtl/mba_pkg.sv
// Shared definitions for the multi-requester memory bus arbiter.
// This package holds the state encoding, the bus direction constants and a debug helper.
package mba_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_GRANT = 2'd1;
  localparam state_t ST_TURN  = 2'd2;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Returns a five-character ASCII name, for use in waveform viewers and debug prints.
  function automatic logic [39:0] state_name(input state_t s);
    case (s)
      ST_IDLE:  state_name = "IDLE ";
      ST_GRANT: state_name = "GRANT";
      ST_TURN:  state_name = "TURN ";
      default:  state_name = "?????";
    endcase
  endfunction

endpackage

// File: rtl/mba_rr_pick.sv
// Combinational picker. It uses either fixed priority (lowest index wins) or a rotating
// priority whose search starts one past the base pointer.
module mba_rr_pick
  import mba_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   base,
  input  logic               rr_en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  int         cand;
  logic [IDX_W-1:0] cand_idx;
  logic       found;

  // base+1+k never exceeds 2*NUM_REQ-1, so a single subtraction performs the wrap.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any_req  = |req;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rr_en) begin
        cand = int'(base) + 1 + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      end else begin
        cand = k;
      end
      cand_idx = IDX_W'(cand);
      if (!found && cand < NUM_REQ && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mba_multi.sv
// Arbiter that grants the single external memory data bus to one of NUM_REQ requesters.
// It inserts a bus turnaround between owners and preempts an owner that starves other requesters.
module mba_multi
  import mba_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int TURNAROUND = 4,
  parameter int RR_EN      = 1,
  parameter int MAX_HOLD   = 16,
  parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_166M66,
  input  logic               mcu_sys_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_rw,
  output logic [NUM_REQ-1:0] o_allow,
  output logic               o_data_bus_enable,
  output logic               o_data_bus_rw,
  output logic [IDX_W-1:0]   o_owner_idx,
  output logic               o_busy
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [3:0]         turn_cnt;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               other_req;
  logic               hold_hit;
  logic               release_bus;
  logic               start_grant;

  mba_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (i_req),
    .base    (rr_ptr),
    .rr_en   (RR_EN != 0),
    .grant   (pick_gnt),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  // In GRANT, o_allow is exactly the owner's bit, so masking it off leaves the other requesters.
  always_comb begin
    other_req   = |(i_req & ~o_allow);
    hold_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && other_req;
    release_bus = !i_req[o_owner_idx] || (i_rw[o_owner_idx] != o_data_bus_rw) || hold_hit;
    start_grant = pick_any &&
                  ((state == ST_IDLE) || ((state == ST_TURN) && (turn_cnt == TURN_LAST)));
  end

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      state             <= ST_IDLE;
      rr_ptr            <= IDX_W'(NUM_REQ - 1);
      hold_cnt          <= '0;
      turn_cnt          <= '0;
      o_allow           <= '0;
      o_data_bus_enable <= 1'b0;
      o_data_bus_rw     <= RW_READ;
      o_owner_idx       <= '0;
      o_busy            <= 1'b0;
    end else if (start_grant) begin
      state             <= ST_GRANT;
      rr_ptr            <= pick_idx;
      hold_cnt          <= '0;
      turn_cnt          <= '0;
      o_allow           <= pick_gnt;
      o_data_bus_enable <= 1'b1;
      o_data_bus_rw     <= i_rw[pick_idx];
      o_owner_idx       <= pick_idx;
      o_busy            <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_GRANT: begin
          if (release_bus) begin
            state             <= ST_TURN;
            turn_cnt          <= '0;
            o_allow           <= '0;
            o_data_bus_enable <= 1'b0;
          end else if (MAX_HOLD != 0 && other_req) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_TURN: begin
          // The last turnaround cycle with no request pending returns the bus to idle.
          if (turn_cnt == TURN_LAST) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt + 4'd1;
          end
        end
        default: begin
          state             <= ST_IDLE;
          o_allow           <= '0;
          o_data_bus_enable <= 1'b0;
          o_busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mba_multi.sv
// Randomized bench for two arbiter configurations, checked against a behavioural bus-ownership model.
// The first configuration uses round-robin with preemption; the second uses fixed priority, 8 requesters and minimal turnaround.
module tb_mba_multi;

  localparam int A_N = 3, A_T = 4, A_RR = 1, A_MH = 2;
  localparam int B_N = 8, B_T = 1, B_RR = 0, B_MH = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_a, rw_a, allow_a;
  logic       en_a, brw_a, busy_a;
  logic [1:0] idx_a;
  logic [7:0] req_b, rw_b, allow_b;
  logic       en_b, brw_b, busy_b;
  logic [2:0] idx_b;

  always #5 clk = ~clk;

  mba_multi #(.NUM_REQ(A_N), .TURNAROUND(A_T), .RR_EN(A_RR), .MAX_HOLD(A_MH)) dut_a (
    .clk_166M66(clk), .mcu_sys_rst_n(rst_n), .i_req(req_a), .i_rw(rw_a),
    .o_allow(allow_a), .o_data_bus_enable(en_a), .o_data_bus_rw(brw_a),
    .o_owner_idx(idx_a), .o_busy(busy_a));

  mba_multi #(.NUM_REQ(B_N), .TURNAROUND(B_T), .RR_EN(B_RR), .MAX_HOLD(B_MH)) dut_b (
    .clk_166M66(clk), .mcu_sys_rst_n(rst_n), .i_req(req_b), .i_rw(rw_b),
    .o_allow(allow_b), .o_data_bus_enable(en_b), .o_data_bus_rw(brw_b),
    .o_owner_idx(idx_b), .o_busy(busy_b));

  int errors = 0;
  int checks = 0;

  // Model: the owner of the bus (-1 if nobody) and how many quiet cycles remain before re-arbitration.
  int p_n[2], p_t[2], p_rr[2], p_mh[2];
  int m_owner[2], m_last[2], m_dir[2], m_held[2], m_quiet[2], m_ptr[2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int pickWinner(input int d, input logic [7:0] req);
    int cand;
    for (int k = 0; k < p_n[d]; k++) begin
      cand = (p_rr[d] != 0) ? (m_ptr[d] + 1 + k) % p_n[d] : k;
      if (req[cand]) return cand;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_last[d] = 0; m_dir[d] = 0;
      m_held[d] = 0; m_quiet[d] = 0; m_ptr[d] = p_n[d] - 1;
    end
  endtask

  task automatic modelStep(input int d, input logic [7:0] req, input logic [7:0] rw);
    int  o, w;
    bit  others;
    if (m_owner[d] >= 0) begin
      o = m_owner[d];
      others = (req & ~(8'd1 << o)) != 8'd0;
      if (!req[o] || int'(rw[o]) != m_dir[d] ||
          (p_mh[d] != 0 && m_held[d] == p_mh[d] - 1 && others)) begin
        m_owner[d] = -1;
        m_quiet[d] = p_t[d];
      end else if (others) begin
        m_held[d]++;
      end
    end else if (m_quiet[d] > 1) begin
      m_quiet[d]--;
    end else begin
      w = pickWinner(d, req);
      m_quiet[d] = 0;
      if (w >= 0) begin
        m_owner[d] = w; m_last[d] = w; m_dir[d] = int'(rw[w]);
        m_held[d] = 0; m_ptr[d] = w;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("a.allow", {29'd0, allow_a}, (m_owner[0] >= 0) ? (32'd1 << m_owner[0]) : 32'd0);
    checkOutput("a.enable", {31'd0, en_a}, 32'(m_owner[0] >= 0));
    checkOutput("a.rw", {31'd0, brw_a}, 32'(m_dir[0]));
    checkOutput("a.owner", {30'd0, idx_a}, 32'(m_last[0]));
    checkOutput("a.busy", {31'd0, busy_a}, 32'(m_owner[0] >= 0 || m_quiet[0] > 0));
    checkOutput("b.allow", {24'd0, allow_b}, (m_owner[1] >= 0) ? (32'd1 << m_owner[1]) : 32'd0);
    checkOutput("b.enable", {31'd0, en_b}, 32'(m_owner[1] >= 0));
    checkOutput("b.rw", {31'd0, brw_b}, 32'(m_dir[1]));
    checkOutput("b.owner", {29'd0, idx_b}, 32'(m_last[1]));
    checkOutput("b.busy", {31'd0, busy_b}, 32'(m_owner[1] >= 0 || m_quiet[1] > 0));
  endtask

  task automatic applyStimulus(input logic [2:0] ra, input logic [2:0] wa,
                               input logic [7:0] rb, input logic [7:0] wb);
    @(negedge clk);
    req_a = ra; rw_a = wa; req_b = rb; rw_b = wb;
    modelStep(0, {5'd0, ra}, {5'd0, wa});
    modelStep(1, rb, wb);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = '0; rw_a = '0; req_b = '0; rw_b = '0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [2:0] ra, wa;
  logic [7:0] rb, wb;
  int         rr_order[$];
  int         rr_exp[4] = '{0, 1, 2, 0};
  logic       prev_en;

  initial begin
    p_n  = '{A_N, B_N}; p_t = '{A_T, B_T};
    p_rr = '{A_RR, B_RR}; p_mh = '{A_MH, B_MH};
    rst_n = 1'b0;
    req_a = '0; rw_a = '0; req_b = '0; rw_b = '0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.allow", {29'd0, allow_a}, 32'd0);
    checkOutput("reset.enable", {31'd0, en_a}, 32'd0);
    checkOutput("reset.owner", {30'd0, idx_a}, 32'd0);
    checkOutput("reset.busy", {31'd0, busy_a}, 32'd0);
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted while requester 0 owns the bus must clear outputs without waiting for a clock edge.
    repeat (3) applyStimulus(3'b001, 3'b000, 8'h01, 8'h00);
    checkOutput("midgrant.pre_enable", {31'd0, en_a}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midgrant.allow_a", {29'd0, allow_a}, 32'd0);
    checkOutput("midgrant.enable_a", {31'd0, en_a}, 32'd0);
    checkOutput("midgrant.busy_a", {31'd0, busy_a}, 32'd0);
    checkOutput("midgrant.allow_b", {24'd0, allow_b}, 32'd0);
    checkOutput("midgrant.enable_b", {31'd0, en_b}, 32'd0);
    req_a = '0; rw_a = '0; req_b = '0; rw_b = '0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b000, 3'b000, 8'h00, 8'h00);

    // Basic read: grant one cycle after the request, then a turnaround after it drops.
    applyStimulus(3'b001, 3'b000, 8'h01, 8'h00);
    checkOutput("basic.allow", {29'd0, allow_a}, 32'd1);
    repeat (4) applyStimulus(3'b001, 3'b000, 8'h01, 8'h00);
    repeat (6) applyStimulus(3'b000, 3'b000, 8'h00, 8'h00);
    checkOutput("basic.idle_busy", {31'd0, busy_a}, 32'd0);

    // Fixed priority on the 8-way instance: the lowest index wins, then the next index after it drops.
    repeat (3) applyStimulus(3'b000, 3'b000, 8'b0000_1010, 8'h00);
    checkOutput("fixed.first", {29'd0, idx_b}, 32'd1);
    repeat (4) applyStimulus(3'b000, 3'b000, 8'b0000_1000, 8'h00);
    checkOutput("fixed.second", {29'd0, idx_b}, 32'd3);
    repeat (3) applyStimulus(3'b000, 3'b000, 8'h00, 8'h00);

    // Round-robin with all three requesting: a fresh pointer starts at 0, and MAX_HOLD forces rotation.
    doReset();
    prev_en = 1'b0;
    repeat (26) begin
      applyStimulus(3'b111, 3'b000, 8'h07, 8'h00);
      if (en_a && !prev_en) rr_order.push_back(int'(idx_a));
      prev_en = en_a;
    end
    checkOutput("rr.count_ok", 32'(rr_order.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < rr_order.size()) checkOutput("rr.order", 32'(rr_order[i]), 32'(rr_exp[i]));
    repeat (6) applyStimulus(3'b000, 3'b000, 8'h00, 8'h00);

    // Owner flips direction mid-grant: expect a turnaround, then a re-grant as a write.
    repeat (3) applyStimulus(3'b001, 3'b000, 8'h01, 8'h00);
    repeat (8) applyStimulus(3'b001, 3'b001, 8'h01, 8'h01);
    checkOutput("toggle.allow", {29'd0, allow_a}, 32'd1);
    checkOutput("toggle.rw", {31'd0, brw_a}, 32'd1);

    // Random traffic: requests and directions flip occasionally, so accesses last several cycles.
    ra = '0; wa = '0; rb = '0; wb = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0) rb[i] = ~rb[i];
        if ($urandom_range(0, 15) == 0) wb[i] = ~wb[i];
        if (i < 3 && $urandom_range(0, 5) == 0) ra[i] = ~ra[i];
        if (i < 3 && $urandom_range(0, 19) == 0) wa[i] = ~wa[i];
      end
      applyStimulus(ra, wa, rb, wb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
